// File: rtl/mvm_uart_pkg.sv
// rtl/mvm_uart_pkg.sv - shared sizing defaults, derived widths and state enums for the UART MVM host
package mvm_uart_pkg;

  localparam int DEF_CLOCKS_PER_PULSE = 200_000_000 / 9600;
  localparam int DEF_BITS_PER_WORD    = 8;
  localparam int DEF_STOP_BITS_TX     = 4;
  localparam int DEF_R                = 8;
  localparam int DEF_C                = 8;
  localparam int DEF_W_K              = 8;
  localparam int DEF_W_X              = 8;
  localparam int DEF_W_Y_OUT          = 32;
  localparam int DEF_TIMEOUT_CYCLES   = 2 ** 24;

  typedef enum logic [1:0] {IDLE, TX, RX_RESP, HOLD} host_state_e;
  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int W_BUS_KX = DEF_R * DEF_C * DEF_W_K + DEF_C * DEF_W_X;
  localparam int W_BUS_Y  = DEF_R * DEF_W_Y_OUT;
  localparam int N_TX     = ceil_div(W_BUS_KX, DEF_BITS_PER_WORD);
  localparam int N_RX     = W_BUS_Y / DEF_BITS_PER_WORD;

endpackage

// File: rtl/mvm_uart_host_if.sv
// rtl/mvm_uart_host_if.sv - operand and result valid/ready streams of the UART MVM host
interface mvm_uart_host_if
  import mvm_uart_pkg::*;
#(
  parameter int W_KX = W_BUS_KX,
  parameter int W_Y  = W_BUS_Y
);
  logic            s_valid;
  logic            s_ready;
  logic [W_KX-1:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [W_Y-1:0]  m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - free-running UART receiver: rx synchronizer, mid-bit sampler, framing check
module uart_byte_rx
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
  parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD
)(
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] data,
  output logic                     valid,
  output logic                     frame_err
);
  localparam int CW = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int BW = $clog2(BITS_PER_WORD + 1);

  rx_state_e              st_q, st_d;
  logic                   sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] sh_q, sh_d;
  logic                   valid_q, valid_d, err_q, err_d;

  always_comb begin
    st_d    = st_q;
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (st_q)
      RX_HUNT: begin
        if (prev_q && !sync2_q) begin
          st_d  = RX_START;
          cnt_d = '0;
        end
      end
      RX_START: begin
        // a start bit that is high again at mid-bit was only a glitch
        if (cnt_q == CW'(CLOCKS_PER_PULSE / 2 - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = sync2_q ? RX_HUNT : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CLOCKS_PER_PULSE - 1)) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[BITS_PER_WORD-1:1]};
          if (bit_q == BW'(BITS_PER_WORD - 1)) st_d = RX_STOP;
          else                                 bit_d = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CLOCKS_PER_PULSE - 1)) begin
          cnt_d   = '0;
          st_d    = RX_HUNT;
          valid_d = sync2_q;
          err_d   = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = RX_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q    <= RX_HUNT;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data      = sh_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
endmodule

// File: rtl/mvm_uart_host.sv
// rtl/mvm_uart_host.sv - sends one K/X operand packet over UART, then assembles the R-row result word
module mvm_uart_host
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = DEF_CLOCKS_PER_PULSE,
  parameter int BITS_PER_WORD    = DEF_BITS_PER_WORD,
  parameter int STOP_BITS_TX     = DEF_STOP_BITS_TX,
  parameter int R                = DEF_R,
  parameter int C                = DEF_C,
  parameter int W_K              = DEF_W_K,
  parameter int W_X              = DEF_W_X,
  parameter int W_Y_OUT          = DEF_W_Y_OUT,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
)(
  input  logic           clk,
  input  logic           rstn,
  mvm_uart_host_if.slave bus,
  output logic           tx,
  input  logic           rx,
  output logic           rx_err,
  output logic           timeout
);
  localparam int KX_W = R * C * W_K + C * W_X;
  localparam int Y_W  = R * W_Y_OUT;
  localparam int NTX  = ceil_div(KX_W, BITS_PER_WORD);
  localparam int NRX  = Y_W / BITS_PER_WORD;
  localparam int SHW  = NTX * BITS_PER_WORD;
  localparam int PCW  = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int BIW  = $clog2(BITS_PER_WORD + STOP_BITS_TX + 1);
  localparam int TBW  = $clog2(NTX + 1);
  localparam int RBW  = $clog2(NRX + 1);
  localparam int IW   = $clog2(TIMEOUT_CYCLES + 1);

  logic [BITS_PER_WORD-1:0] rx_byte;
  logic                     byte_valid, frame_err;

  uart_byte_rx #(
    .CLOCKS_PER_PULSE (CLOCKS_PER_PULSE),
    .BITS_PER_WORD    (BITS_PER_WORD)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .data      (rx_byte),
    .valid     (byte_valid),
    .frame_err (frame_err)
  );

  host_state_e    state_q, state_d;
  logic           s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic           tx_q, tx_d, rx_err_q, rx_err_d, timeout_q, timeout_d;
  logic [SHW-1:0] sh_q, sh_d;
  logic [Y_W-1:0] m_data_q, m_data_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [BIW-1:0] bidx_q, bidx_d;
  logic [TBW-1:0] txb_q, txb_d;
  logic [RBW-1:0] rxc_q, rxc_d;
  logic [IW-1:0]  idle_q, idle_d;

  always_comb begin
    state_d   = state_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    tx_d      = tx_q;
    rx_err_d  = frame_err;
    timeout_d = 1'b0;
    sh_d      = sh_q;
    m_data_d  = m_data_q;
    pcnt_d    = pcnt_q;
    bidx_d    = bidx_q;
    txb_d     = txb_q;
    rxc_d     = rxc_q;
    idle_d    = idle_q;
    case (state_q)
      IDLE: begin
        if (bus.s_valid && s_ready_q) begin
          sh_d      = SHW'(bus.s_data);
          state_d   = TX;
          s_ready_d = 1'b0;
          tx_d      = 1'b0;
          pcnt_d    = '0;
          bidx_d    = '0;
          txb_d     = '0;
        end
      end
      TX: begin
        // bidx: 0 = start, 1..BITS_PER_WORD = data, then the stop bits
        if (pcnt_q == PCW'(CLOCKS_PER_PULSE - 1)) begin
          pcnt_d = '0;
          if (bidx_q == BIW'(BITS_PER_WORD + STOP_BITS_TX)) begin
            if (txb_q == TBW'(NTX - 1)) begin
              state_d = RX_RESP;
              tx_d    = 1'b1;
              idle_d  = '0;
              rxc_d   = '0;
            end else begin
              txb_d  = txb_q + 1'b1;
              sh_d   = sh_q >> BITS_PER_WORD;
              bidx_d = '0;
              tx_d   = 1'b0;
            end
          end else begin
            bidx_d = bidx_q + 1'b1;
            tx_d   = (bidx_q < BIW'(BITS_PER_WORD)) ? sh_q[bidx_q] : 1'b1;
          end
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      RX_RESP: begin
        if (byte_valid) begin
          m_data_d = {rx_byte, m_data_q[Y_W-1:BITS_PER_WORD]};
          idle_d   = '0;
          if (rxc_q == RBW'(NRX - 1)) begin
            state_d   = HOLD;
            m_valid_d = 1'b1;
            rxc_d     = '0;
          end else begin
            rxc_d = rxc_q + 1'b1;
          end
        end else if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          s_ready_d = 1'b1;
          idle_d    = '0;
          rxc_d     = '0;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
          s_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
      tx_q      <= 1'b1;
      rx_err_q  <= 1'b0;
      timeout_q <= 1'b0;
      sh_q      <= '0;
      m_data_q  <= '0;
      pcnt_q    <= '0;
      bidx_q    <= '0;
      txb_q     <= '0;
      rxc_q     <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      tx_q      <= tx_d;
      rx_err_q  <= rx_err_d;
      timeout_q <= timeout_d;
      sh_q      <= sh_d;
      m_data_q  <= m_data_d;
      pcnt_q    <= pcnt_d;
      bidx_q    <= bidx_d;
      txb_q     <= txb_d;
      rxc_q     <= rxc_d;
      idle_q    <= idle_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign tx          = tx_q;
  assign rx_err      = rx_err_q;
  assign timeout     = timeout_q;
endmodule

// File: tb/tb_mvm_uart_host.sv
// tb/tb_mvm_uart_host.sv - directed/random bench for mvm_uart_host against a frame-level reference model
module tb_mvm_uart_host;
  localparam int CPP   = 4;
  localparam int BPW   = 8;
  localparam int STOPS = 4;
  localparam int R = 2, C = 2, W_K = 8, W_X = 8, W_Y_OUT = 32, TMO = 1000;
  localparam int W_KX  = R * C * W_K + C * W_X;
  localparam int W_Y   = R * W_Y_OUT;
  localparam int N_TX  = 6;
  localparam int N_RX  = 8;
  localparam int FRAME = CPP * (1 + BPW + STOPS);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic rx = 1'b1;
  logic tx, rx_err, timeout;

  mvm_uart_host_if #(.W_KX(W_KX), .W_Y(W_Y)) bus ();

  mvm_uart_host #(
    .CLOCKS_PER_PULSE (CPP),
    .BITS_PER_WORD    (BPW),
    .STOP_BITS_TX     (STOPS),
    .R                (R),
    .C                (C),
    .W_K              (W_K),
    .W_X              (W_X),
    .W_Y_OUT          (W_Y_OUT),
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .bus     (bus),
    .tx      (tx),
    .rx      (rx),
    .rx_err  (rx_err),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_cnt = 0, tmo_cnt = 0, tmo_cyc = 0, mv_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn) begin
      if (rx_err) err_cnt <= err_cnt + 1;
      if (timeout) begin
        tmo_cnt <= tmo_cnt + 1;
        tmo_cyc <= cyc;
      end
      if (bus.m_valid) mv_cnt <= mv_cnt + 1;
    end
  end

  initial begin
    #1_000_000;
    $fatal(1, "FAIL watchdog: simulation did not complete");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected tx level t cycles after packet acceptance, from the frame format alone
  function automatic logic exp_tx(input logic [47:0] d, input int t);
    int b   = t / FRAME;
    int pos = (t % FRAME) / CPP;
    if (pos == 0) return 1'b0;
    if (pos <= BPW) return d[b * 8 + pos - 1];
    return 1'b1;
  endfunction

  task automatic send_packet(input logic [47:0] d);
    int bad_tx[N_TX] = '{default: 0};
    int bad_rdy = 0;
    int w = 0;
    while (!bus.s_ready && w < 2000) begin
      tick();
      w++;
    end
    check("pkt_s_ready", 64'(bus.s_ready), 64'(1));
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    tick();
    for (int t = 0; t < N_TX * FRAME; t++) begin
      bus.s_valid = 1'($urandom_range(0, 1));
      bus.s_data  = {$urandom, $urandom};
      if (tx !== exp_tx(d, t)) bad_tx[t / FRAME]++;
      if (bus.s_ready !== 1'b0) bad_rdy++;
      tick();
    end
    bus.s_valid = 1'b0;
    for (int b = 0; b < N_TX; b++) check($sformatf("tx_byte%0d", b), 64'(bad_tx[b]), 64'(0));
    check("tx_s_ready_low", 64'(bad_rdy), 64'(0));
    check("tx_idle_after", 64'(tx), 64'(1));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (CPP) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPP) tick();
    end
    rx = stop_ok;
    repeat (CPP) tick();
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (CPP) tick();
    end
    rx = 1'b1;
  endtask

  task automatic expect_result(input logic [63:0] exp, input int hold);
    int w = 0;
    int bad = 0;
    while (!bus.m_valid && w < 60) begin
      tick();
      w++;
    end
    check("m_valid_rise", 64'(bus.m_valid), 64'(1));
    check("m_data", bus.m_data, exp);
    repeat (hold) begin
      bus.m_ready = 1'b0;
      tick();
      if (bus.m_valid !== 1'b1 || bus.m_data !== exp) bad++;
    end
    check("hold_stable", 64'(bad), 64'(0));
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    check("m_valid_drop", 64'(bus.m_valid), 64'(0));
    check("s_ready_back", 64'(bus.s_ready), 64'(1));
  endtask

  initial begin
    logic [63:0] r64;
    logic [63:0] exp_y;
    logic [7:0]  b;
    int bad, e0, t0, m0, f_end, w;

    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b0;
    rstn = 1'b0;
    repeat (3) tick();
    check("rst_tx", 64'(tx), 64'(1));
    check("rst_m_valid", 64'(bus.m_valid), 64'(0));
    check("rst_rx_err", 64'(rx_err), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_m_data", bus.m_data, 64'(0));
    rstn = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (tx !== 1'b1 || bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0 ||
          rx_err !== 1'b0 || timeout !== 1'b0) bad++;
    end
    check("idle_20", 64'(bad), 64'(0));

    // fixed packet, then 8N1 response 11..88
    send_packet(48'h060504030201);
    for (int k = 0; k < N_RX; k++) begin
      b = 8'(17 * (k + 1));
      send_byte(b, 1'b1);
    end
    expect_result(64'h8877665544332211, 10);
    check("no_err_clean", 64'(err_cnt), 64'(0));
    check("no_tmo_clean", 64'(tmo_cnt), 64'(0));

    // bad stop bit on response byte 3, then timeout
    r64 = {$urandom, $urandom};
    send_packet(r64[47:0]);
    e0 = err_cnt;
    m0 = mv_cnt;
    t0 = tmo_cnt;
    for (int k = 0; k < N_RX; k++) send_byte(8'($urandom), k != 3);
    f_end = cyc;
    w = 0;
    while (tmo_cnt == t0 && w < 1200) begin
      tick();
      w++;
    end
    check("rx_err_pulses", 64'(err_cnt - e0), 64'(1));
    check("timeout_seen", 64'(tmo_cnt - t0), 64'(1));
    check("timeout_window", 64'((tmo_cyc - f_end) >= 990 && (tmo_cyc - f_end) <= 1020), 64'(1));
    check("idle_after_timeout", 64'(bus.s_ready), 64'(1));
    repeat (5) tick();
    check("timeout_single", 64'(tmo_cnt - t0), 64'(1));
    check("no_m_valid_on_timeout", 64'(mv_cnt - m0), 64'(0));

    // one-cycle glitch, then a random response
    r64 = {$urandom, $urandom};
    send_packet(r64[47:0]);
    e0 = err_cnt;
    rx = 1'b0;
    tick();
    rx = 1'b1;
    repeat (12) tick();
    exp_y = '0;
    for (int k = 0; k < N_RX; k++) begin
      b = 8'($urandom);
      exp_y[k * 8 +: 8] = b;
      send_byte(b, 1'b1);
    end
    expect_result(exp_y, 3);
    check("glitch_no_err", 64'(err_cnt - e0), 64'(0));

    // reset in the middle of byte 2 of TX
    bus.s_valid = 1'b1;
    bus.s_data  = 48'hA5A5_5A5A_C3C3;
    tick();
    bus.s_valid = 1'b0;
    m0 = mv_cnt;
    repeat (2 * FRAME + 20 - 1) tick();
    rstn = 1'b0;
    tick();
    check("midrst_tx", 64'(tx), 64'(1));
    check("midrst_m_valid", 64'(bus.m_valid), 64'(0));
    rstn = 1'b1;
    tick();
    check("midrst_s_ready", 64'(bus.s_ready), 64'(1));
    r64 = {$urandom, $urandom};
    send_packet(r64[47:0]);
    check("midrst_no_m_valid", 64'(mv_cnt - m0), 64'(0));
    exp_y = '0;
    for (int k = 0; k < N_RX; k++) begin
      b = 8'($urandom);
      exp_y[k * 8 +: 8] = b;
      send_byte(b, 1'b1);
    end
    expect_result(exp_y, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
